apb_slave_regbank: RTL and testbench
====================================

// Module: apb_slave_regbank
// PURPOSE
//   APB slave endpoint sitting directly downstream of the APB master interface on the same bus.
//   Decodes one address window and implements a bank of REG_NUM read/write word registers.
//   Inserts a programmable number of wait states and flags protocol/decode faults on apb_slverr_out.
// PARAMETERS
//   APB_DATA_WIDTH  32  data bus width; multiple of 8
//   APB_ADDR_WIDTH  32  address bus width
//   REG_NUM         8   number of word registers; >= 1
//   BASE_ADDR       0   byte address of register 0; word aligned
//   WAIT_CYCLES     0   extra ACCESS cycles before pready; 0..15
// PORTS
//   apb_clk_in       in   1                 APB clock
//   apb_rstn_in      in   1                 asynchronous, active-low reset
//   apb_psel_in      in   1                 slave select
//   apb_penable_in   in   1                 enable (access phase)
//   apb_write_in     in   1                 1 = write, 0 = read
//   apb_addr_in      in   APB_ADDR_WIDTH    byte address
//   apb_wdata_in     in   APB_DATA_WIDTH    write data
//   apb_strb_in      in   APB_DATA_WIDTH/8  byte strobes (APB_SLV_WSTRB_EN only)
//   apb_rdata_out    out  APB_DATA_WIDTH    read data, valid while apb_ready_out=1
//   apb_ready_out    out  1                 transfer complete, registered
//   apb_slverr_out   out  1                 error response, valid while apb_ready_out=1
// BEHAVIOUR
//   Reset: clock apb_clk_in; reset apb_rstn_in, asynchronous, active-low.
//   Reset values: apb_rdata_out=0, apb_ready_out=0, apb_slverr_out=0, all registers=0, state=IDLE, wait counter=0.
//   FSM is one-hot with states IDLE, ACCESS and RESP. All outputs are registered on posedge.
//   IDLE:
//     - psel=1 & penable=0 -> latch addr, write and wdata (and strb); counter=0; go ACCESS.
//     - Any other input combination -> stay IDLE.
//   ACCESS:
//     - psel=0 -> abort: no register update, no response; go IDLE.
//     - penable=0 -> hold state; counter unchanged.
//     - penable=1, counter<WAIT_CYCLES -> counter++.
//     - penable=1, counter==WAIT_CYCLES -> ready<=1, perform decode/access; go RESP.
//   RESP:
//     - ready<=0, slverr<=0, rdata<=0.
//     - psel=1 & penable=0 -> back-to-back setup: latch inputs as in IDLE; go ACCESS.
//     - Otherwise go IDLE.
//   Latency: the access phase lasts WAIT_CYCLES+2 clocks, i.e. WAIT_CYCLES+1 wait states, then a 1-clock ready pulse.
//   Decode:
//     - offset = latched addr - BASE_ADDR, computed at APB_ADDR_WIDTH and wrapping.
//     - Valid iff offset[1:0]==0 and offset>>2 < REG_NUM. Word addressing is fixed at 4 bytes.
//   Valid write: reg[offset>>2] <= latched wdata, updated on the same edge as ready<=1. rdata<=0.
//   Valid read: rdata <= reg[offset>>2].
//   Error (slverr<=1 with ready<=1, no register update, rdata<=0) when any of:
//     - the address is invalid, or
//     - apb_addr_in, apb_write_in or apb_wdata_in (on writes) differ from the latched copy in any ACCESS cycle with penable=1.
//   Stability violation: the error sticks until the response; the counter still runs to WAIT_CYCLES.
//   Reset asserted mid-transfer: immediate return to reset values; no partial write.
// CONFIGURATION
//   APB_SLV_WSTRB_EN defined:
//     - apb_strb_in exists and is latched in setup, with a stability check as for addr.
//     - A write updates only bytes whose strobe=1; strb=0 writes nothing but responds OK.
//     - Reads ignore strb.
//   APB_SLV_WSTRB_EN undefined: port absent; every write updates the full word.
// TESTING
//   1. Reset -> outputs 0; read 0x0..0x1C each -> rdata=0, slverr=0.
//   2. WAIT_CYCLES=0: write 0x8 <= 0xDEADBEEF, read 0x8 -> ready after 2 enable clocks, rdata=0xDEADBEEF.
//   3. WAIT_CYCLES=3: write then read 0x4 -> ready in 5th enable clock; data 0x12345678 returned.
//   4. Read 0x20 (REG_NUM=8), then write 0x6 -> both slverr=1, ready=1, rdata=0; registers unchanged.
//   5. Change addr 0x4 -> 0x8 during wait states -> slverr=1; neither register written.
//   6. APB_SLV_WSTRB_EN: reg 0x0=0x11223344, write 0xAABBCCDD strb=4'b0101 -> read 0x11BB33DD.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// -----------------------------------------------------------------------------
// apb_slave_regbank
//   APB slave endpoint decoding a single address window onto a bank of REG_NUM
//   read/write word registers. A programmable number of wait states is inserted
//   before the one-clock ready pulse. Decode faults and master-side stability
//   violations are reported on apb_slverr_out.
//
//   Optional feature macro: APB_SLV_WSTRB_EN
//     defined   -> apb_strb_in exists; writes update only strobed bytes.
//     undefined -> no strobe port; every write updates the full word.
//
// Ports
//   apb_clk_in      in   APB clock
//   apb_rstn_in     in   asynchronous active-low reset
//   apb_psel_in     in   slave select
//   apb_penable_in  in   access-phase enable
//   apb_write_in    in   1 = write, 0 = read
//   apb_addr_in     in   byte address
//   apb_wdata_in    in   write data
//   apb_strb_in     in   byte strobes (APB_SLV_WSTRB_EN only)
//   apb_rdata_out   out  read data, valid while apb_ready_out=1
//   apb_ready_out   out  transfer complete (registered pulse)
//   apb_slverr_out  out  error response, valid while apb_ready_out=1
// -----------------------------------------------------------------------------
module apb_slave_regbank #(
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        REG_NUM        = 8,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        WAIT_CYCLES    = 0
) (
    input  logic                        apb_clk_in,
    input  logic                        apb_rstn_in,
    input  logic                        apb_psel_in,
    input  logic                        apb_penable_in,
    input  logic                        apb_write_in,
    input  logic [APB_ADDR_WIDTH-1:0]   apb_addr_in,
    input  logic [APB_DATA_WIDTH-1:0]   apb_wdata_in,
`ifdef APB_SLV_WSTRB_EN
    input  logic [APB_DATA_WIDTH/8-1:0] apb_strb_in,
`endif
    output logic [APB_DATA_WIDTH-1:0]   apb_rdata_out,
    output logic                        apb_ready_out,
    output logic                        apb_slverr_out
);

    localparam int STRB_W = APB_DATA_WIDTH / 8;
    localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    // One-hot state encoding
    localparam logic [2:0] IDLE   = 3'b001;
    localparam logic [2:0] ACCESS = 3'b010;
    localparam logic [2:0] RESP   = 3'b100;

    logic [2:0]                state;
    logic [3:0]                wait_cnt;
    logic                      err_sticky;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
`ifdef APB_SLV_WSTRB_EN
    logic [STRB_W-1:0]         strb_q;
`endif
    logic [APB_DATA_WIDTH-1:0] regs [REG_NUM];

    logic                      setup;
    logic                      latch_en;
    logic [APB_ADDR_WIDTH-1:0] offset;
    logic [APB_ADDR_WIDTH-1:0] word;
    logic                      addr_ok;
    logic [IDX_W-1:0]          idx;
    logic                      unstable;
    logic                      viol;
    logic                      wait_done;
    logic [APB_DATA_WIDTH-1:0] wmask;
    logic [APB_DATA_WIDTH-1:0] merged;

    assign setup    = apb_psel_in & ~apb_penable_in;
    // A new setup phase is accepted from IDLE and, back-to-back, from RESP.
    assign latch_en = setup & ((state == IDLE) | (state == RESP));

    // Offset wraps at the address width, so addresses below BASE_ADDR land
    // far above the window and decode as invalid.
    assign offset  = addr_q - BASE_ADDR;
    assign word    = offset >> 2;
    assign addr_ok = (offset[1:0] == 2'b00) && (word < APB_ADDR_WIDTH'(REG_NUM));
    assign idx     = word[IDX_W-1:0];

    always_comb begin
        unstable = (apb_addr_in != addr_q) | (apb_write_in != write_q) |
                   (write_q & (apb_wdata_in != wdata_q));
`ifdef APB_SLV_WSTRB_EN
        unstable = unstable | (apb_strb_in != strb_q);
`endif
    end

    // Once a violation is seen it sticks until the response is issued.
    assign viol      = err_sticky | unstable;
    assign wait_done = (wait_cnt == 4'(WAIT_CYCLES));

    always_comb begin
        wmask = '1;
`ifdef APB_SLV_WSTRB_EN
        for (int b = 0; b < STRB_W; b++) begin
            wmask[b*8 +: 8] = {8{strb_q[b]}};
        end
`endif
    end

    assign merged = (regs[idx] & ~wmask) | (wdata_q & wmask);

    // Setup-phase capture of the transfer attributes
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef APB_SLV_WSTRB_EN
            strb_q  <= '0;
`endif
        end else if (latch_en) begin
            addr_q  <= apb_addr_in;
            write_q <= apb_write_in;
            wdata_q <= apb_wdata_in;
`ifdef APB_SLV_WSTRB_EN
            strb_q  <= apb_strb_in;
`endif
        end
    end

    // Control FSM, response outputs and register bank
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            err_sticky     <= 1'b0;
            apb_ready_out  <= 1'b0;
            apb_slverr_out <= 1'b0;
            apb_rdata_out  <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        wait_cnt   <= '0;
                        err_sticky <= 1'b0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!apb_psel_in) begin
                        // Master abandoned the transfer: no update, no response.
                        state <= IDLE;
                    end else if (apb_penable_in) begin
                        if (!wait_done) begin
                            wait_cnt   <= wait_cnt + 4'd1;
                            err_sticky <= viol;
                        end else begin
                            apb_ready_out <= 1'b1;
                            state         <= RESP;
                            if (viol || !addr_ok) begin
                                apb_slverr_out <= 1'b1;
                                apb_rdata_out  <= '0;
                            end else if (write_q) begin
                                regs[idx]     <= merged;
                                apb_rdata_out <= '0;
                            end else begin
                                apb_rdata_out <= regs[idx];
                            end
                        end
                    end
                end
                RESP: begin
                    apb_ready_out  <= 1'b0;
                    apb_slverr_out <= 1'b0;
                    apb_rdata_out  <= '0;
                    if (setup) begin
                        wait_cnt   <= '0;
                        err_sticky <= 1'b0;
                        state      <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regbank
//   Two slaves on independent buses: u0 without wait states, u1 with three.
//   Stimulus pushes the expected response per transfer into a per-slave queue;
//   a monitor pops and compares whenever a slave raises ready.
// -----------------------------------------------------------------------------
module tb_apb_slave_regbank;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        psel  [2];
    logic        pen   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb  [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        err   [2];

    apb_slave_regbank #(.WAIT_CYCLES(0)) u0 (
        .apb_clk_in(clk), .apb_rstn_in(rstn),
        .apb_psel_in(psel[0]), .apb_penable_in(pen[0]), .apb_write_in(wr[0]),
        .apb_addr_in(addr[0]), .apb_wdata_in(wdata[0]),
`ifdef APB_SLV_WSTRB_EN
        .apb_strb_in(strb[0]),
`endif
        .apb_rdata_out(rdata[0]), .apb_ready_out(rdy[0]), .apb_slverr_out(err[0])
    );

    apb_slave_regbank #(.WAIT_CYCLES(3)) u1 (
        .apb_clk_in(clk), .apb_rstn_in(rstn),
        .apb_psel_in(psel[1]), .apb_penable_in(pen[1]), .apb_write_in(wr[1]),
        .apb_addr_in(addr[1]), .apb_wdata_in(wdata[1]),
`ifdef APB_SLV_WSTRB_EN
        .apb_strb_in(strb[1]),
`endif
        .apb_rdata_out(rdata[1]), .apb_ready_out(rdy[1]), .apb_slverr_out(err[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   ecnt[2];
    logic done = 1'b0;

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL u%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                chk(d, "reset_ready",  {31'd0, rdy[d]}, 32'd0);
                chk(d, "reset_slverr", {31'd0, err[d]}, 32'd0);
                chk(d, "reset_rdata",  rdata[d],        32'd0);
                ecnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (psel[d] && pen[d]) ecnt[d] = ecnt[d] + 1;
                else                   ecnt[d] = 0;
                if (rdy[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL u%0d unexpected_ready: got ready=1 expected none at %0t", d, $time);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk(d, "rdata",   rdata[d],         e.rdata);
                        chk(d, "slverr",  {31'd0, err[d]},  {31'd0, e.err});
                        chk(d, "latency", ecnt[d],          e.lat);
                    end
                end
            end
        end
        if (done) begin
            chk(0, "pending_responses", q0.size(), 0);
            chk(1, "pending_responses", q1.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // One complete transfer. chg_at>0 moves the address to chg_a after that
    // many enable clocks, to provoke a stability violation.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sb, input logic [31:0] exp_rd, input logic exp_err,
                        input int chg_at = 0, input logic [31:0] chg_a = 32'd0);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        psel[d] = 1'b1; pen[d] = 1'b0; wr[d] = w; addr[d] = a; wdata[d] = wd; strb[d] = sb;
        e.rdata = exp_rd; e.err = exp_err; e.lat = (d == 0) ? 2 : 5;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        pen[d] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == chg_at) addr[d] = chg_a;
        end while (!rdy[d] && n < 40);
        if (!rdy[d]) begin
            $display("FAIL u%0d ready_timeout: got no ready expected one within 40 clocks", d);
            $fatal(1);
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; pen[d] = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish expected one before 600us");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; pen[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; strb[d] = 4'hF;
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Every register reads zero after reset
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 32'd0, 4'hF, 32'd0, 1'b0);
            xfer(1, 1'b0, 32'(i * 4), 32'd0, 4'hF, 32'd0, 1'b0);
        end

        // No wait states: write/read back, including the last register
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'd0,        1'b0);
        xfer(0, 1'b0, 32'h08, 32'd0,        4'hF, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b1, 32'h1C, 32'hA5A50F0F, 4'hF, 32'd0,        1'b0);
        xfer(0, 1'b0, 32'h1C, 32'd0,        4'hF, 32'hA5A50F0F, 1'b0);

        // Three wait states
        xfer(1, 1'b1, 32'h04, 32'h12345678, 4'hF, 32'd0,        1'b0);
        xfer(1, 1'b0, 32'h04, 32'd0,        4'hF, 32'h12345678, 1'b0);

        // Out-of-window read and misaligned write both error; nothing changes
        xfer(0, 1'b0, 32'h20, 32'd0,        4'hF, 32'd0,        1'b1);
        xfer(0, 1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 32'd0,        1'b1);
        xfer(0, 1'b0, 32'h04, 32'd0,        4'hF, 32'd0,        1'b0);
        xfer(0, 1'b0, 32'h08, 32'd0,        4'hF, 32'hDEADBEEF, 1'b0);

        // Address changes during wait states: error, neither register written
        xfer(1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, 32'd0, 1'b1, 2, 32'h08);
        xfer(1, 1'b0, 32'h04, 32'd0,        4'hF, 32'h12345678, 1'b0);
        xfer(1, 1'b0, 32'h08, 32'd0,        4'hF, 32'd0,        1'b0);

        // Aborted write (psel dropped during wait states) has no effect
        @(posedge clk); #1;
        psel[1] = 1'b1; pen[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h0C; wdata[1] = 32'h55;
        @(posedge clk); #1 pen[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 psel[1] = 1'b0; pen[1] = 1'b0;
        repeat (2) @(posedge clk);
        xfer(1, 1'b0, 32'h0C, 32'd0, 4'hF, 32'd0, 1'b0);

`ifdef APB_SLV_WSTRB_EN
        // Byte strobes
        xfer(0, 1'b1, 32'h00, 32'h11223344, 4'hF,    32'd0,        1'b0);
        xfer(0, 1'b1, 32'h00, 32'hAABBCCDD, 4'b0101, 32'd0,        1'b0);
        xfer(0, 1'b0, 32'h00, 32'd0,        4'h0,    32'h11BB33DD, 1'b0);
        xfer(0, 1'b1, 32'h00, 32'hFFFFFFFF, 4'h0,    32'd0,        1'b0);
        xfer(0, 1'b0, 32'h00, 32'd0,        4'hF,    32'h11BB33DD, 1'b0);
`endif

        // Reset in the middle of a write: registers return to zero, no write
        @(posedge clk); #1;
        psel[0] = 1'b1; pen[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h77;
        @(posedge clk); #1;
        pen[0] = 1'b1; rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 psel[0] = 1'b0; pen[0] = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        xfer(0, 1'b0, 32'h10, 32'd0, 4'hF, 32'd0, 1'b0);
        xfer(0, 1'b0, 32'h08, 32'd0, 4'hF, 32'd0, 1'b0);

        repeat (3) @(posedge clk);
        done = 1'b1;
    end

endmodule
